// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the seven-segment scan controller.
//   DEFAULT_CLK_DIV : default dwell per digit, in clock cycles
//   SEG_PATTERN     : hex digit -> active-low {g,f,e,d,c,b,a} pattern
//   SEG_BLANK       : all segments dark
//   disp_data_t     : one captured frame {value, dot_mask, blank_mask}
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int DEFAULT_CLK_DIV = 100000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_t;

  localparam digit_t LAST_DIGIT = 2'd3;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dot_mask;
    logic [3:0]  blank_mask;
  } disp_data_t;

endpackage

// File: rtl/seven_seg_scan_controller_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_controller_if
// Bundles the host-side load bus and the display-side scan outputs.
//   Value[15:0]               four hex digits, digit 0 rightmost
//   Load                      one-cycle capture strobe
//   DotMask[3:0]              bit n set = decimal point n lit
//   BlankMask[3:0]            bit n set = digit n dark
//   DisplayElementSelect[1:0] digit currently driven (to anode selector)
//   SEG[6:0]                  active-low cathodes {g,f,e,d,c,b,a}
//   DP                        active-low decimal point
//   ScanTick                  pulse coincident with each digit change
// master = host/display side, slave = controller.
// ---------------------------------------------------------------------------
interface seven_seg_scan_controller_if;

  logic [15:0] Value;
  logic        Load;
  logic [3:0]  DotMask;
  logic [3:0]  BlankMask;
  logic [1:0]  DisplayElementSelect;
  logic [6:0]  SEG;
  logic        DP;
  logic        ScanTick;

  modport master (
    output Value, Load, DotMask, BlankMask,
    input  DisplayElementSelect, SEG, DP, ScanTick
  );

  modport slave (
    input  Value, Load, DotMask, BlankMask,
    output DisplayElementSelect, SEG, DP, ScanTick
  );

endinterface

// File: rtl/hex_to_seven_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seven_seg
// Purely combinational hex-nibble to seven-segment decoder.
//   hex[3:0] : nibble to display
//   seg[6:0] : active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seven_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_PATTERN[hex];
  end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_controller
// Time-multiplexes four hex digits onto a common-cathode-bus display.
// A prescaler sets the dwell per digit; a 2-bit digit counter selects the
// digit. Loads land in a pending register that is promoted to the displayed
// register only at the digit 3 -> 0 advance, so a frame never mixes data.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : slave modport (Value/Load/DotMask/BlankMask in,
//           DisplayElementSelect/SEG/DP/ScanTick out)
// ---------------------------------------------------------------------------
module seven_seg_scan_controller
  import seg_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                         Clk,
  input  logic                         Reset,
  seven_seg_scan_controller_if.slave   bus
);

  localparam int                PRE_W    = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  digit_t           digit;
  digit_t           digit_next;
  disp_data_t       pending;
  disp_data_t       displayed;
  disp_data_t       load_data;
  disp_data_t       show_data;
  logic             advance;
  logic             frame_wrap;
  logic [3:0]       nibble;
  logic [6:0]       decoded;
  logic [6:0]       seg_next;
  logic             dp_next;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             tick_q;

  // Outputs are computed for the digit being advanced to, so anode and
  // cathode registers update on the same edge. At a frame wrap the data for
  // digit 0 comes from what the displayed register is about to become,
  // which includes a Load arriving in that very cycle.
  always_comb begin
    advance    = (prescaler == PRE_LAST);
    frame_wrap = advance && (digit == LAST_DIGIT);
    digit_next = digit + 2'd1;
    load_data  = {bus.Value, bus.DotMask, bus.BlankMask};
    show_data  = displayed;
    if (frame_wrap) begin
      show_data = bus.Load ? load_data : pending;
    end
    nibble   = show_data.value[{digit_next, 2'b00} +: 4];
    seg_next = show_data.blank_mask[digit_next] ? SEG_BLANK : decoded;
    dp_next  = show_data.blank_mask[digit_next] | ~show_data.dot_mask[digit_next];
  end

  hex_to_seven_seg u_decode (
    .hex (nibble),
    .seg (decoded)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prescaler <= '0;
      digit     <= '0;
      pending   <= '0;
      displayed <= '0;
      seg_q     <= SEG_PATTERN[0];
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= advance;
      if (advance) begin
        prescaler <= '0;
        digit     <= digit_next;
        seg_q     <= seg_next;
        dp_q      <= dp_next;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
      if (bus.Load) begin
        pending <= load_data;
      end
      if (frame_wrap) begin
        displayed <= show_data;
      end
    end
  end

  assign bus.DisplayElementSelect = digit;
  assign bus.SEG                  = seg_q;
  assign bus.DP                   = dp_q;
  assign bus.ScanTick             = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_controller
// Scoreboard bench for seven_seg_scan_controller with CLK_DIV = 4.
// The stimulus process pushes the hand-computed {digit, SEG, DP} expected at
// each upcoming ScanTick; the monitor pops on every ScanTick, checks tick
// spacing, and checks that outputs hold steady between ticks.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_controller;

  typedef struct packed {
    logic [1:0] digit;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  int   vectors = 0;
  int   miscompares = 0;
  int   cur = 0;
  exp_t exp_q[$];

  exp_t hold;
  bit   hold_valid = 1'b0;
  bit   have_prev = 1'b0;
  int   gap = 0;

  seven_seg_scan_controller_if bus_if();

  seven_seg_scan_controller #(.CLK_DIV(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [6:0] s, input logic p);
    exp_q.push_back({d, s, p});
  endtask

  // One clock: returns just after the rising edge, cur = next edge index.
  task automatic step();
    @(posedge Clk);
    #1;
    cur++;
  endtask

  task automatic run_to(input int c);
    while (cur < c) step();
  endtask

  // Presents a Load so that it is sampled on edge index c.
  task automatic apply_stimulus(input int c, input logic [15:0] value,
                                input logic [3:0] dot, input logic [3:0] blank);
    run_to(c);
    bus_if.Value     = value;
    bus_if.DotMask   = dot;
    bus_if.BlankMask = blank;
    bus_if.Load      = 1'b1;
    step();
    bus_if.Load      = 1'b0;
  endtask

  task automatic check_output(input string tag);
    check({tag, "_select"}, 16'(bus_if.DisplayElementSelect), 16'd0);
    check({tag, "_seg"},    16'(bus_if.SEG),                  16'h40);
    check({tag, "_dp"},     16'(bus_if.DP),                   16'd1);
    check({tag, "_tick"},   16'(bus_if.ScanTick),             16'd0);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      hold       = {2'd0, 7'h40, 1'b1};
      hold_valid = 1'b1;
      have_prev  = 1'b0;
      gap        = 0;
    end else if (hold_valid) begin
      gap++;
      if (bus_if.ScanTick === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_tick: got select %0d, expected no tick at %0t",
                   bus_if.DisplayElementSelect, $time);
          hold_valid = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("tick_select", 16'(bus_if.DisplayElementSelect), 16'(e.digit));
          check("tick_seg",    16'(bus_if.SEG),                  16'(e.seg));
          check("tick_dp",     16'(bus_if.DP),                   16'(e.dp));
          hold = e;
        end
        if (have_prev) check("tick_spacing", 16'(gap), 16'd4);
        have_prev = 1'b1;
        gap       = 0;
      end else begin
        check("hold_select", 16'(bus_if.DisplayElementSelect), 16'(hold.digit));
        check("hold_seg",    16'(bus_if.SEG),                  16'(hold.seg));
        check("hold_dp",     16'(bus_if.DP),                   16'(hold.dp));
      end
    end
  end

  initial begin
    exp_t e;
    bus_if.Value     = 16'h0;
    bus_if.DotMask   = 4'h0;
    bus_if.BlankMask = 4'h0;
    bus_if.Load      = 1'b0;

    // Free run after reset: ticks at edges 3,7,11,15 then 19,23,27.
    push(2'd1, 7'h40, 1'b1);
    push(2'd2, 7'h40, 1'b1);
    push(2'd3, 7'h40, 1'b1);
    push(2'd0, 7'h40, 1'b1);
    push(2'd1, 7'h40, 1'b1);
    push(2'd2, 7'h40, 1'b1);
    push(2'd3, 7'h40, 1'b1);

    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    cur   = 0;
    check_output("reset");

    // Mid-frame load becomes visible at the edge-31 frame wrap.
    push(2'd0, 7'h03, 1'b1);
    push(2'd1, 7'h08, 1'b0);
    push(2'd2, 7'h24, 1'b1);
    push(2'd3, 7'h79, 1'b1);
    apply_stimulus(21, 16'h12AB, 4'b0010, 4'b0000);

    // Load exactly on the edge-47 frame wrap shows at once.
    push(2'd0, 7'h0E, 1'b1);
    push(2'd1, 7'h0E, 1'b1);
    push(2'd2, 7'h0E, 1'b1);
    push(2'd3, 7'h0E, 1'b1);
    apply_stimulus(47, 16'hFFFF, 4'b0000, 4'b0000);

    // Blanking overrides dots on digits 2,3 (frame from edge 63).
    push(2'd0, 7'h19, 1'b0);
    push(2'd1, 7'h30, 1'b0);
    push(2'd2, 7'h7F, 1'b1);
    push(2'd3, 7'h7F, 1'b1);
    apply_stimulus(53, 16'h1234, 4'b1111, 4'b1100);

    // Two loads in one frame: only 2222h reaches the edge-79 frame.
    apply_stimulus(65, 16'h1111, 4'b0000, 4'b0000);
    push(2'd0, 7'h24, 1'b1);
    push(2'd1, 7'h24, 1'b1);
    push(2'd2, 7'h24, 1'b1);
    apply_stimulus(69, 16'h2222, 4'b0000, 4'b0000);

    // Reset with Load at digit 2, prescaler 3 (edge 91): load discarded,
    // full dwell restarts, so ticks at 95,99,103,107 show zeros.
    push(2'd1, 7'h40, 1'b1);
    push(2'd2, 7'h40, 1'b1);
    push(2'd3, 7'h40, 1'b1);
    push(2'd0, 7'h40, 1'b1);
    run_to(91);
    bus_if.Value     = 16'h9999;
    bus_if.DotMask   = 4'b1111;
    bus_if.BlankMask = 4'b0000;
    bus_if.Load      = 1'b1;
    Reset            = 1'b1;
    step();
    Reset       = 1'b0;
    bus_if.Load = 1'b0;
    check_output("mid_reset");

    run_to(112);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_tick: got none, expected select %0d seg %0h dp %0d",
               e.digit, e.seg, e.dp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

Interface
REQ-001 Parameter CLK_DIV, default 100000, clock cycles each digit is displayed (legal range 2..2^20).
REQ-002 Clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Value  input  16  four hex digits; digit n = Value[4n+3:4n], digit 0 rightmost.
REQ-005 Load  input  1  one-cycle strobe; SHALL capture Value, DotMask and BlankMask.
REQ-006 DotMask  input  4  bit n set = decimal point of digit n lit.
REQ-007 BlankMask  input  4  bit n set = digit n fully dark.
REQ-008 DisplayElementSelect  output  2  index of the digit being driven; feeds the 2-to-4 anode selector.
REQ-009 SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 DP  output  1  decimal point, active-low.
REQ-011 ScanTick  output  1  one-cycle pulse in the cycle DisplayElementSelect advances.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and the digit counter advances in the same edge.
REQ-013 Digit counter SHALL count 0,1,2,3,0 modulo 4; DisplayElementSelect is its registered value.
REQ-014 ScanTick SHALL be high for exactly the one cycle following each advance edge, i.e. coincident with the new DisplayElementSelect.
REQ-015 Load SHALL write a pending register {Value, DotMask, BlankMask}; the displayed register SHALL copy the pending register only on the advance from digit 3 to digit 0 (frame boundary), so no frame shows mixed data.
REQ-016 Load in the same cycle as a frame-boundary advance SHALL send the new inputs directly to the displayed register (and pending).
REQ-017 Back-to-back Loads within one frame: last one wins.
REQ-018 SEG, DP SHALL be registered and SHALL change in the same edge as DisplayElementSelect, derived from the displayed register and the next digit index (zero skew between anode and cathode).
REQ-019 Hex decode (active-low gfedcba): 0=40h,1=79h,2=24h,3=30h,4=19h,5=12h,6=02h,7=78h,8=00h,9=10h,A=08h,b=03h,C=46h,d=21h,E=06h,F=0Eh.
REQ-020 Blanked digit: SEG=7Fh and DP=1 regardless of DotMask.
REQ-021 Non-blanked digit: DP = ~DotMask[n].
REQ-022 Prescaler width SHALL be $clog2(CLK_DIV); no overflow beyond CLK_DIV-1.

Reset
REQ-023 Reset asserted SHALL, at the next edge, set prescaler=0, digit=0, pending and displayed registers=0, DisplayElementSelect=0, SEG=40h, DP=1, ScanTick=0.
REQ-024 Reset SHALL take priority over Load and over an advance in the same cycle; reset mid-frame restarts at digit 0 with full CLK_DIV dwell.

Structure
REQ-025 Package seg_pkg SHALL hold the 16-entry segment pattern constants, SEG_BLANK (7Fh) and the default CLK_DIV.
REQ-026 Decode SHALL be one combinational sub-module hex_to_seven_seg (4-bit in, 7-bit active-low out); the controller instantiates it once on the muxed nibble.
REQ-027 DisplayElementSelect SHALL connect unmodified to the existing 2-to-4 anode selector at top level.

Verification (CLK_DIV=4)
REQ-028 Reset, release, free run 20 cycles -> DisplayElementSelect 0,1,2,3,0 changing every 4 cycles; ScanTick one pulse per change; SEG=40h throughout.
REQ-029 Load Value=12ABh, DotMask=0010b, BlankMask=0 mid-frame -> old data until digit 3->0 advance, then digits 0..3 show 03h,08h,24h,79h; DP=0 only at digit 1.
REQ-030 Load Value=FFFFh in the exact frame-boundary cycle -> next digit 0 shows 0Eh immediately.
REQ-031 BlankMask=1100b, DotMask=1111b -> digits 2,3 SEG=7Fh DP=1; digits 0,1 DP=0.
REQ-032 Two Loads (1111h then 2222h) in one frame -> next frame all digits 24h; 1111h never displayed.
REQ-033 Reset asserted at digit 2 prescaler 3 together with Load -> next cycle digit 0, SEG=40h, ScanTick=0, loaded value discarded.
